// File: rtl/garage_pkg.sv
// garage_pkg: shared constants and helpers for the car-park occupancy controller.
//   CAPACITY_DEF - default maximum occupancy
//   LANES_DEF    - default number of entry lanes (and of exit lanes)
//   DENIED_W     - width of the saturating refused-entry tally
//   calc_cw()    - occupancy counter width for a given capacity
package garage_pkg;

   localparam int CAPACITY_DEF = 50;
   localparam int LANES_DEF    = 2;
   localparam int DENIED_W     = 16;

   // Counter must hold 0..cap inclusive.
   function automatic int calc_cw(input int cap);
      return $clog2(cap + 1);
   endfunction

endpackage

// File: rtl/lane_event_detect.sv
// lane_event_detect: per-lane rising-edge detector for sensor levels.
//   clk, reset - clock and asynchronous active-high reset
//   sens       - W sensor levels (1 = car present)
//   evt        - W rising-edge events (sens & ~previous sens), combinational
// The previous-level register clears on reset, so a sensor held high across
// reset release yields one event on the first edge after release.
module lane_event_detect #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] sens,
   output logic [W-1:0] evt
);

   logic [W-1:0] prev_q, prev_d;

   always_comb begin
      prev_d = sens;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev_q <= '0;
      else       prev_q <= prev_d;
   end

   assign evt = sens & ~prev_q;

endmodule

// File: rtl/garage_occupancy_ctrl.sv
// garage_occupancy_ctrl: multi-lane car-park occupancy controller.
//   clk, reset    - clock and asynchronous active-high reset
//   clear         - synchronous clear of occupancy and refused tally
//   entry_sens    - per-lane entry sensor levels
//   exit_sens     - per-lane exit sensor levels
//   entry_grant   - registered 1-cycle pulse, entry accepted
//   entry_reject  - registered 1-cycle pulse, entry refused (lot full)
//   exit_grant    - registered 1-cycle pulse, exit accepted
//   count         - current occupancy
//   free_slots    - CAPACITY - count
//   full / empty / almost_full - flags decoded from count
//   denied_total  - saturating tally of entry_reject pulses
module garage_occupancy_ctrl
   import garage_pkg::*;
#(
   parameter  int CAPACITY  = CAPACITY_DEF,
   parameter  int LANES     = LANES_DEF,
   parameter  int AF_MARGIN = 5,
   localparam int CW        = calc_cw(CAPACITY)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic [LANES-1:0]    entry_sens,
   input  logic [LANES-1:0]    exit_sens,
   output logic [LANES-1:0]    entry_grant,
   output logic [LANES-1:0]    entry_reject,
   output logic [LANES-1:0]    exit_grant,
   output logic [CW-1:0]       count,
   output logic [CW-1:0]       free_slots,
   output logic                full,
   output logic                empty,
   output logic                almost_full,
   output logic [DENIED_W-1:0] denied_total
);

   logic [LANES-1:0] entry_evt, exit_evt;

   lane_event_detect #(.W(LANES)) u_entry_det (
      .clk   (clk),
      .reset (reset),
      .sens  (entry_sens),
      .evt   (entry_evt)
   );

   lane_event_detect #(.W(LANES)) u_exit_det (
      .clk   (clk),
      .reset (reset),
      .sens  (exit_sens),
      .evt   (exit_evt)
   );

   logic [CW-1:0]       count_q, count_d;
   logic [DENIED_W-1:0] denied_q, denied_d;
   logic [LANES-1:0]    entry_grant_q, entry_grant_d;
   logic [LANES-1:0]    entry_reject_q, entry_reject_d;
   logic [LANES-1:0]    exit_grant_q, exit_grant_d;

   logic [CW-1:0]       ex_budget, en_budget;
   logic [CW-1:0]       n_ent, n_ex;
   logic [2:0]          n_rej;
   logic [DENIED_W:0]   den_sum;

   // Priority grant with a running budget, lowest lane first. Both budgets
   // come from count_q, so slots freed by same-cycle exits are not reused
   // and the grant totals can never move count outside 0..CAPACITY.
   always_comb begin
      ex_budget      = count_q;
      en_budget      = CW'(CAPACITY) - count_q;
      n_ent          = '0;
      n_ex           = '0;
      n_rej          = '0;
      entry_grant_d  = '0;
      entry_reject_d = '0;
      exit_grant_d   = '0;
      for (int i = 0; i < LANES; i++) begin
         if (exit_evt[i] && (ex_budget != '0)) begin
            exit_grant_d[i] = 1'b1;
            ex_budget       = ex_budget - CW'(1);
            n_ex            = n_ex + CW'(1);
         end
         if (entry_evt[i]) begin
            if (en_budget != '0) begin
               entry_grant_d[i] = 1'b1;
               en_budget        = en_budget - CW'(1);
               n_ent            = n_ent + CW'(1);
            end else begin
               entry_reject_d[i] = 1'b1;
               n_rej             = n_rej + 3'd1;
            end
         end
      end

      count_d  = count_q + n_ent - n_ex;

      // One spare bit catches the carry for saturation.
      den_sum  = {1'b0, denied_q} + (DENIED_W+1)'(n_rej);
      denied_d = den_sum[DENIED_W] ? '1 : den_sum[DENIED_W-1:0];

      // Clear overrides every event; edge detectors keep tracking regardless.
      if (clear) begin
         count_d        = '0;
         denied_d       = '0;
         entry_grant_d  = '0;
         entry_reject_d = '0;
         exit_grant_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q        <= '0;
         denied_q       <= '0;
         entry_grant_q  <= '0;
         entry_reject_q <= '0;
         exit_grant_q   <= '0;
      end else begin
         count_q        <= count_d;
         denied_q       <= denied_d;
         entry_grant_q  <= entry_grant_d;
         entry_reject_q <= entry_reject_d;
         exit_grant_q   <= exit_grant_d;
      end
   end

   assign count        = count_q;
   assign free_slots   = CW'(CAPACITY) - count_q;
   assign full         = (count_q == CW'(CAPACITY));
   assign empty        = (count_q == '0);
   assign almost_full  = (int'(free_slots) <= AF_MARGIN);
   assign denied_total = denied_q;
   assign entry_grant  = entry_grant_q;
   assign entry_reject = entry_reject_q;
   assign exit_grant   = exit_grant_q;

endmodule

// File: tb/tb_garage_occupancy_ctrl.sv
// tb_garage_occupancy_ctrl: directed test of garage_occupancy_ctrl with
// default parameters (CAPACITY 50, LANES 2, AF_MARGIN 5).
module tb_garage_occupancy_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic [1:0]  entry_sens, exit_sens;
   logic [1:0]  entry_grant, entry_reject, exit_grant;
   logic [5:0]  count, free_slots;
   logic        full, empty, almost_full;
   logic [15:0] denied_total;

   int n_chk  = 0;
   int n_fail = 0;

   garage_occupancy_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .entry_sens   (entry_sens),
      .exit_sens    (exit_sens),
      .entry_grant  (entry_grant),
      .entry_reject (entry_reject),
      .exit_grant   (exit_grant),
      .count        (count),
      .free_slots   (free_slots),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .denied_total (denied_total)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One rising event on both entry lanes, then release: +2 occupancy.
   task automatic pair_in();
      entry_sens = 2'b11; step();
      entry_sens = 2'b00; step();
   endtask

   int ngr;

   initial begin
      reset = 1'b1; clear = 1'b0; entry_sens = '0; exit_sens = '0;
      step(); step();
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_free", free_slots, 50);
      chk("rst_denied", denied_total, 0);
      chk("rst_grant", {entry_grant, entry_reject, exit_grant}, 0);
      reset = 1'b0;

      // Single entry on lane 0.
      entry_sens = 2'b01; step();
      chk("e0_grant", entry_grant, 2'b01);
      chk("e0_count", count, 1);
      chk("e0_empty", empty, 0);
      entry_sens = 2'b00; step();
      chk("e0_pulse_end", entry_grant, 0);
      chk("e0_count_hold", count, 1);

      // Fill to 49 two at a time, probing the almost_full boundary.
      for (int k = 0; k < 24; k++) begin
         pair_in();
         if (k == 20) chk("af_at43", almost_full, 0);
         if (k == 21) chk("af_at45", almost_full, 1);
      end
      chk("fill_count49", count, 49);
      chk("fill_full49", full, 0);

      // count 49, two entries: lane 0 granted, lane 1 refused.
      entry_sens = 2'b11; step();
      chk("last_grant", entry_grant, 2'b01);
      chk("last_reject", entry_reject, 2'b10);
      chk("last_count", count, 50);
      chk("last_full", full, 1);
      chk("last_free", free_slots, 0);
      chk("last_denied", denied_total, 1);
      entry_sens = 2'b00; step();
      chk("rej_pulse_end", entry_reject, 0);

      // Full lot, another entry: refused.
      entry_sens = 2'b01; step();
      chk("full_reject", entry_reject, 2'b01);
      chk("full_count", count, 50);
      chk("full_denied", denied_total, 2);
      entry_sens = 2'b00; step();

      // Full lot, entry lane 0 with exit lane 1: exit frees a slot too late.
      entry_sens = 2'b01; exit_sens = 2'b10; step();
      chk("mix_entry_grant", entry_grant, 0);
      chk("mix_entry_reject", entry_reject, 2'b01);
      chk("mix_exit_grant", exit_grant, 2'b10);
      chk("mix_count", count, 49);
      chk("mix_denied", denied_total, 3);
      entry_sens = 2'b00; exit_sens = 2'b00; step();

      // Clear.
      clear = 1'b1; step();
      clear = 1'b0;
      chk("clr_count", count, 0);
      chk("clr_denied", denied_total, 0);
      chk("clr_empty", empty, 1);

      // Exit from empty lot is dropped.
      exit_sens = 2'b01; step();
      chk("empty_exit_grant", exit_grant, 0);
      chk("empty_exit_count", count, 0);
      exit_sens = 2'b00; step();

      // Held entry sensor produces exactly one grant.
      ngr = 0;
      entry_sens = 2'b01;
      for (int k = 0; k < 10; k++) begin
         step();
         if (entry_grant[0]) ngr++;
      end
      chk("hold_grants", ngr, 1);
      chk("hold_count", count, 1);
      entry_sens = 2'b00; step();

      // Two exits with only one car: lowest lane wins.
      exit_sens = 2'b11; step();
      chk("exit_arb_grant", exit_grant, 2'b01);
      chk("exit_arb_count", count, 0);
      exit_sens = 2'b00; step();

      // Reach 20, then clear with a simultaneous entry.
      for (int k = 0; k < 10; k++) pair_in();
      chk("c20_count", count, 20);
      clear = 1'b1; entry_sens = 2'b01; step();
      chk("clr_entry_grant", entry_grant, 0);
      chk("clr_entry_count", count, 0);
      clear = 1'b0; entry_sens = 2'b00; step();

      // Async reset mid-stream, sensor held high across release.
      entry_sens = 2'b01; step();
      chk("pre_rst_grant", entry_grant, 2'b01);
      chk("pre_rst_count", count, 1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_grant", entry_grant, 0);
      chk("async_rst_count", count, 0);
      chk("async_rst_free", free_slots, 50);
      step();
      reset = 1'b0;
      step();
      chk("post_rst_grant", entry_grant, 2'b01);
      chk("post_rst_count", count, 1);
      step();
      chk("post_rst_once", entry_grant, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
